// File: rtl/fpu_wb_buffer.sv
// Write-back buffer between the ftoi stage and the integer register file.
// Show-ahead FIFO of {add, data} results with a pending-register scoreboard.
module fpu_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [31:0]              data_in,
  input  logic                     flag_in,
  input  logic [4:0]               add_in,
  input  logic                     wb_ready,
  output logic                     wb_we,
  output logic [4:0]               wb_add,
  output logic [31:0]              wb_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [31:0]              pending,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    add_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic enq_req;
  logic deq;
  logic enq;
  logic drop;

  // Writes to r0 are meaningless, so they never occupy a slot.
  assign enq_req = flag_in && (add_in != 5'd0);
  assign full    = (count == CW'(DEPTH));
  assign deq     = (count != '0) && wb_ready;
  assign enq     = enq_req && (!full || deq);
  assign drop    = enq_req && full && !deq;

  assign wb_we   = deq;
  assign wb_add  = add_mem[rd_ptr];
  assign wb_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rstn && enq) begin
      add_mem[wr_ptr]  <= add_in;
      data_mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)
        count <= count + 1'b1;
      else if (!enq && deq)
        count <= count - 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < count)
        pending[add_mem[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule
